// File: rtl/arm_pkg.sv
// Shared constants for the 16-bit Harvard core sequencer and ALU.
// State one-hot codes double as the sequencer's state encoding.
package arm_pkg;

    localparam logic [3:0] ST_FETCH = 4'b0001;
    localparam logic [3:0] ST_EXEC1 = 4'b0010;
    localparam logic [3:0] ST_EXEC2 = 4'b0100;
    localparam logic [3:0] ST_EXEC3 = 4'b1000;

    // ALU subclasses live in IR[14:12] when IR[15] is set
    localparam logic [2:0] OP_LDR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_STR = 3'b111;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_HALT = 5'b00001;
    localparam logic [4:0] OP_B    = 5'b00010;
    localparam logic [4:0] OP_BZ   = 5'b00011;

    typedef enum logic [3:0] {
        S_HALT  = 4'b0000,
        S_FETCH = ST_FETCH,
        S_EXEC1 = ST_EXEC1,
        S_EXEC2 = ST_EXEC2,
        S_EXEC3 = ST_EXEC3
    } seq_state_t;

endpackage

// File: rtl/arm_pc.sv
// Program counter: increment on fetch, signed imm8 branch add.
// All arithmetic wraps modulo 2^PC_W.
module arm_pc #(
    parameter int PC_W = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            inc,
    input  logic            br_take,
    input  logic [7:0]      imm8,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] off;

    assign off = PC_W'($signed(imm8));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RST_PC;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end else if (br_take) begin
            pc <= pc + off;
        end
    end

endmodule

// File: rtl/arm_seq.sv
// Instruction fetch and multi-cycle sequencer feeding the ALU stage.
// The state register is itself the one-hot state bus (HALT encodes as zero).
module arm_seq
    import arm_pkg::*;
#(
    parameter int PC_W = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [15:0]     imem_data,
    input  logic            rd_zero,
    output logic [PC_W-1:0] imem_addr,
    output logic [4:0]      inst,
    output logic [2:0]      rd_sel,
    output logic [2:0]      rs_sel,
    output logic [3:0]      state,
    output logic            dmem_wen,
    output logic            halted,
    output logic [15:0]     retired
);

    seq_state_t cur, nxt;
    logic [15:0] ir;
    logic ir_load, pc_inc, br_take, last;
    logic is_ldr, is_mul, is_str, is_halt, is_br;

    assign is_ldr  = ir[15] && (ir[14:12] == OP_LDR);
    assign is_mul  = ir[15] && (ir[14:12] == OP_MUL);
    assign is_str  = ir[15] && (ir[14:12] == OP_STR);
    assign is_halt = (ir[15:11] == OP_HALT);
    assign is_br   = (ir[15:11] == OP_B)
                  || ((ir[15:11] == OP_BZ) && rd_zero);

    always_comb begin
        nxt     = cur;
        ir_load = 1'b0;
        pc_inc  = 1'b0;
        br_take = 1'b0;
        last    = 1'b0;
        unique case (cur)
            S_FETCH: begin
                if (run) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    nxt     = S_EXEC1;
                end
            end
            S_EXEC1: begin
                br_take = is_br;
                if (is_halt) begin
                    nxt  = S_HALT;
                    last = 1'b1;
                end else if (is_ldr || is_mul) begin
                    nxt = S_EXEC2;
                end else begin
                    nxt  = S_FETCH;
                    last = 1'b1;
                end
            end
            S_EXEC2: begin
                if (is_mul) begin
                    nxt = S_EXEC3;
                end else begin
                    nxt  = S_FETCH;
                    last = 1'b1;
                end
            end
            S_EXEC3: begin
                nxt  = S_FETCH;
                last = 1'b1;
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= S_FETCH;
            ir      <= '0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (ir_load) ir <= imem_data;
            if (last) retired <= retired + 16'd1;
        end
    end

    arm_pc #(
        .PC_W   (PC_W),
        .RST_PC (RST_PC)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .inc     (pc_inc),
        .br_take (br_take),
        .imm8    (ir[7:0]),
        .pc      (imem_addr)
    );

    assign state    = cur;
    assign inst     = ir[15:11];
    assign rd_sel   = ir[10:8];
    assign rs_sel   = ir[7:5];
    assign dmem_wen = (cur == S_EXEC1) && is_str;
    assign halted   = (cur == S_HALT);

endmodule

// File: tb/tb_arm_seq.sv
// Bench for arm_seq: program table plus hand-written reset/halt/wrap sequences.
module tb_arm_seq;

    logic clk = 1'b0;
    logic reset, run, run2, rd_zero;
    logic [7:0] addr, addr2;
    logic [15:0] data, data2;
    logic [4:0] inst, w_inst;
    logic [2:0] rd_sel, rs_sel, w_rd, w_rs;
    logic [3:0] state, w_state;
    logic dmem_wen, halted, w_wen, w_halted;
    logic [15:0] retired, w_ret;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    assign data  = mem[addr];
    assign data2 = mem[addr2];

    arm_seq #(.PC_W(8), .RST_PC(8'h00)) u_dut (
        .clk(clk), .reset(reset), .run(run), .imem_data(data),
        .rd_zero(rd_zero), .imem_addr(addr), .inst(inst),
        .rd_sel(rd_sel), .rs_sel(rs_sel), .state(state),
        .dmem_wen(dmem_wen), .halted(halted), .retired(retired)
    );

    arm_seq #(.PC_W(8), .RST_PC(8'hFF)) u_wrap (
        .clk(clk), .reset(reset), .run(run2), .imem_data(data2),
        .rd_zero(1'b0), .imem_addr(addr2), .inst(w_inst),
        .rd_sel(w_rd), .rs_sel(w_rs), .state(w_state),
        .dmem_wen(w_wen), .halted(w_halted), .retired(w_ret)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic        wen;
        logic [7:0]  addr;
        logic [10:0] ir;
        logic [15:0] ret;
        logic        halted;
    } exp_t;

    typedef struct {
        logic [15:0] word;
        logic        rdz;
        int          lat;
        logic [7:0]  next;
        logic        wen;
    } vec_t;

    exp_t sb[$];
    vec_t prog[16];
    int total = 0;
    int bad = 0;
    string tag;
    logic [7:0] epc;
    logic [15:0] last_ir, eret;

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s/%s: got %0h want %0h t=%0t",
                     tag, nm, act, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic wen,
                                input logic [7:0] a, input logic [15:0] w,
                                input logic [15:0] r, input logic h);
        exp_t e;
        e.st = st;
        e.wen = wen;
        e.addr = a;
        e.ir = w[15:5];
        e.ret = r;
        e.halted = h;
        return e;
    endfunction

    task automatic check(input exp_t e);
        exp_t g;
        sb.push_back(e);
        g = sb.pop_front();
        cmp("state", state, g.st);
        cmp("dmem_wen", dmem_wen, g.wen);
        cmp("imem_addr", addr, g.addr);
        cmp("ir", {inst, rd_sel, rs_sel}, g.ir);
        cmp("retired", retired, g.ret);
        cmp("halted", halted, g.halted);
    endtask

    task automatic step(input exp_t e);
        check(e);
        @(negedge clk);
    endtask

    task automatic run_instr(input vec_t v);
        mem[epc] = v.word;
        rd_zero = v.rdz;
        run = 1'b1;
        step(mk(4'b0001, 1'b0, epc, last_ir, eret, 1'b0));
        last_ir = v.word;
        for (int k = 1; k < v.lat; k++) begin
            run = 1'($urandom_range(0, 1));
            step(mk(4'(1 << k), v.wen && (k == 1),
                    (k == 1) ? epc + 8'd1 : v.next,
                    last_ir, eret, 1'b0));
        end
        eret = eret + 16'd1;
        epc = v.next;
    endtask

    initial begin
        prog[0]  = '{16'h83A0, 1'b0, 2, 8'h01, 1'b0};
        prog[1]  = '{16'hE120, 1'b0, 3, 8'h02, 1'b0};
        prog[2]  = '{16'hD240, 1'b0, 4, 8'h03, 1'b0};
        prog[3]  = '{16'hF760, 1'b0, 2, 8'h04, 1'b1};
        prog[4]  = '{16'h0000, 1'b0, 2, 8'h05, 1'b0};
        prog[5]  = '{16'h10FC, 1'b0, 2, 8'h02, 1'b0};
        prog[6]  = '{16'h0000, 1'b1, 2, 8'h03, 1'b0};
        prog[7]  = '{16'h0000, 1'b0, 2, 8'h04, 1'b0};
        prog[8]  = '{16'h0000, 1'b0, 2, 8'h05, 1'b0};
        prog[9]  = '{16'h1803, 1'b0, 2, 8'h06, 1'b0};
        prog[10] = '{16'h10FE, 1'b0, 2, 8'h05, 1'b0};
        prog[11] = '{16'h1803, 1'b1, 2, 8'h09, 1'b0};
        prog[12] = '{16'h10E6, 1'b0, 2, 8'hF0, 1'b0};
        prog[13] = '{16'h107F, 1'b0, 2, 8'h70, 1'b0};
        prog[14] = '{16'h3800, 1'b0, 2, 8'h71, 1'b0};
        prog[15] = '{16'h0800, 1'b0, 2, 8'h72, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1;
        run = 1'b0;
        run2 = 1'b0;
        rd_zero = 1'b0;
        epc = 8'h00;
        last_ir = 16'h0000;
        eret = 16'h0000;
        repeat (2) @(negedge clk);

        tag = "reset";
        check(mk(4'b0001, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0));
        cmp("w_state", w_state, 4'b0001);
        cmp("w_addr", addr2, 8'hFF);
        cmp("w_ir", {w_inst, w_rd, w_rs}, 11'h000);
        cmp("w_misc", {w_wen, w_halted, w_ret}, 18'h0);
        reset = 1'b0;
        @(negedge clk);

        tag = "wrap";
        run2 = 1'b1;
        @(negedge clk);
        run2 = 1'b0;
        cmp("w_addr", addr2, 8'h00);
        cmp("w_state", w_state, 4'b0010);

        tag = "prog";
        for (int i = 0; i < 4; i++) run_instr(prog[i]);
        cmp("retired4", retired, 16'd4);
        cmp("addr4", addr, 8'h04);

        tag = "stall";
        run = 1'b0;
        repeat (5) step(mk(4'b0001, 1'b0, epc, last_ir, eret, 1'b0));

        tag = "branch";
        for (int i = 4; i < 16; i++) run_instr(prog[i]);

        tag = "halt";
        repeat (20) begin
            run = 1'($urandom_range(0, 1));
            step(mk(4'b0000, 1'b0, epc, last_ir, eret, 1'b1));
        end
        cmp("halt_ret", retired, 16'd16);

        tag = "halt_reset";
        reset = 1'b1;
        #1;
        check(mk(4'b0001, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0));
        @(negedge clk);
        reset = 1'b0;
        epc = 8'h00;
        last_ir = 16'h0000;
        eret = 16'h0000;
        run_instr('{16'h0000, 1'b0, 2, 8'h01, 1'b0});

        tag = "mid_reset";
        mem[1] = 16'hE120;
        run = 1'b1;
        step(mk(4'b0001, 1'b0, 8'h01, last_ir, eret, 1'b0));
        last_ir = 16'hE120;
        step(mk(4'b0010, 1'b0, 8'h02, last_ir, eret, 1'b0));
        check(mk(4'b0100, 1'b0, 8'h02, last_ir, eret, 1'b0));
        reset = 1'b1;
        #1;
        check(mk(4'b0001, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0));
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check(mk(4'b0001, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
